// File: rtl/inst_encoder_if.sv
// Request and instruction-memory write bus between a program source and the encoder.
// The master drives decoded instructions; the slave (encoder) returns the handshake and write port.
interface inst_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [2:0]        in_funct3;
  logic              in_alt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              iw_we;
  logic [ADDR_W-1:0] iw_addr;
  logic [31:0]       iw_data;
  logic              err;
  logic [ADDR_W:0]   count;
  logic              full;

  modport master (
    output in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, iw_we, iw_addr, iw_data, err, count, full
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, iw_we, iw_addr, iw_data, err, count, full
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder / program loader: packs decoded instructions into words
// and writes them to sequential instruction-memory addresses; LI expands to LUI+ADDI.
module inst_encoder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  inst_encoder_if.slave bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [0:0] {IDLE, LI2} state_t;

  function automatic logic fits(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              iw_we_q, iw_we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] iw_addr_q, iw_addr_d;
  logic [31:0]       iw_data_q, iw_data_d;
  logic [31:0]       pend_q, pend_d;

  logic              full, accept;
  logic [6:0]        f7;
  logic [2:0]        f3;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm;
  logic signed [31:0] simm;
  logic [31:0]       li_sum;
  logic [31:0]       word_a, word_b;
  logic              ok, two;

  assign full   = (count_q == DEPTH_C);
  assign accept = bus.in_valid && (state_q == IDLE) && !full;

  always_comb begin
    f3     = bus.in_funct3;
    rd     = bus.in_rd;
    rs1    = bus.in_rs1;
    rs2    = bus.in_rs2;
    imm    = bus.in_imm;
    simm   = $signed(bus.in_imm);
    f7     = bus.in_alt ? 7'b0100000 : 7'b0000000;
    li_sum = bus.in_imm + 32'h0000_0800;
    word_a = '0;
    word_b = '0;
    ok     = 1'b1;
    two    = 1'b0;
    case (bus.in_kind)
      4'd0: word_a = {f7, rs2, rs1, f3, rd, OP_R};
      4'd1: begin
        // Shift-immediates carry funct7 in the upper immediate bits and a 5-bit shamt
        if (f3 == 3'b001 || f3 == 3'b101) begin
          word_a = {f7, imm[4:0], rs1, f3, rd, OP_I};
          ok     = (imm[31:5] == 27'd0);
        end else begin
          word_a = {imm[11:0], rs1, f3, rd, OP_I};
          ok     = fits(simm, -2048, 2047);
        end
      end
      4'd2: begin
        word_a = {imm[11:0], rs1, f3, rd, OP_LOAD};
        ok     = fits(simm, -2048, 2047);
      end
      4'd3: begin
        word_a = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        ok     = fits(simm, -2048, 2047);
      end
      4'd4: begin
        word_a = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
        ok     = fits(simm, -2048, 2047);
      end
      4'd5: begin
        word_a = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
        ok     = fits(simm, -4096, 4094) && !imm[0];
      end
      4'd6: word_a = {imm[31:12], rd, OP_LUI};
      4'd7: begin
        word_a = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        ok     = fits(simm, -1048576, 1048574) && !imm[0];
      end
      4'd8: begin
        // The +0x800 pre-bias compensates for ADDI sign-extending the low 12 bits
        if (li_sum[31:12] == 20'd0) begin
          word_a = {imm[11:0], 5'd0, 3'b000, rd, OP_I};
        end else begin
          two    = 1'b1;
          word_a = {li_sum[31:12], rd, OP_LUI};
          word_b = {imm[11:0], rd, 3'b000, rd, OP_I};
          ok     = (count_q != LAST_C);
        end
      end
      default: ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    iw_we_d   = 1'b0;
    err_d     = 1'b0;
    iw_addr_d = iw_addr_q;
    iw_data_d = iw_data_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!ok) begin
            err_d = 1'b1;
          end else begin
            iw_we_d   = 1'b1;
            iw_addr_d = count_q[ADDR_W-1:0];
            iw_data_d = word_a;
            count_d   = count_q + ONE_C;
            if (two) begin
              state_d = LI2;
              pend_d  = word_b;
            end
          end
        end
      end
      LI2: begin
        iw_we_d   = 1'b1;
        iw_addr_d = count_q[ADDR_W-1:0];
        iw_data_d = pend_q;
        count_d   = count_q + ONE_C;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear abandons any pending ADDI and restarts the program at address 0
    if (clear) begin
      state_d   = IDLE;
      count_d   = '0;
      iw_addr_d = '0;
      iw_we_d   = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      iw_we_q   <= 1'b0;
      err_q     <= 1'b0;
      iw_addr_q <= '0;
      iw_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      iw_we_q   <= iw_we_d;
      err_q     <= err_d;
      iw_addr_q <= iw_addr_d;
      iw_data_q <= iw_data_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign bus.in_ready = (state_q == IDLE) && !full;
  assign bus.iw_we    = iw_we_q;
  assign bus.iw_addr  = iw_addr_q;
  assign bus.iw_data  = iw_data_q;
  assign bus.err      = err_q;
  assign bus.count    = count_q;
  assign bus.full     = full;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed cases plus randomized requests
// compared against an arithmetic reference model of the RV32I encodings.
module tb_inst_encoder;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int mcount = 0;
  logic [31:0] last_w0, last_w1;
  logic        last_err;
  int bnd [23] = '{-2049, -2048, -2047, 2046, 2047, 2048, -4097, -4096, -4095, 4094, 4095, 4096,
                   -1048577, -1048576, 1048574, 1048575, 1048576, 31, 32, 0, -1, -7, -8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: expected error flag, number of words, and the words themselves
  function automatic void model(input int k, input int f3, input bit alt, input int rd, input int rs1,
                                input int rs2, input int imm, output bit e, output int n,
                                output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] u, hi, lo, f7;
    u  = imm;
    f7 = alt ? 32'd32 : 32'd0;
    lo = u & 32'hFFF;
    e  = 1'b0; n = 1; w0 = '0; w1 = '0;
    case (k)
      0: w0 = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: if (f3 == 1 || f3 == 5) begin
           e  = (u > 32'd31);
           w0 = (f7 << 25) | ((u & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         end else begin
           e  = !(imm >= -2048 && imm <= 2047);
           w0 = (lo << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         end
      2: begin
           e  = !(imm >= -2048 && imm <= 2047);
           w0 = (lo << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
         end
      3: begin
           e  = !(imm >= -2048 && imm <= 2047);
           w0 = (lo << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
         end
      4: begin
           e  = !(imm >= -2048 && imm <= 2047);
           w0 = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u & 31) << 7) | 32'h23;
         end
      5: begin
           e  = !(imm >= -4096 && imm <= 4094 && (imm % 2 == 0));
           w0 = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
              | (f3 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
         end
      6: w0 = (u & 32'hFFFFF000) | (rd << 7) | 32'h37;
      7: begin
           e  = !(imm >= -1048576 && imm <= 1048574 && (imm % 2 == 0));
           w0 = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
              | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
         end
      8: begin
           hi = (u + 32'h800) >> 12;
           if (hi == 0) begin
             w0 = (lo << 20) | (rd << 7) | 32'h13;
           end else begin
             n  = 2;
             w0 = (hi << 12) | (rd << 7) | 32'h37;
             w1 = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
             e  = (mcount == DEPTH - 1);
           end
         end
      default: e = 1'b1;
    endcase
  endfunction

  // Called at a falling edge; presents one request and checks the resulting cycle(s)
  task automatic do_req(input int k, input int f3, input bit alt, input int rd, input int rs1,
                        input int rs2, input int imm);
    bit e; int n; logic [31:0] w0, w1; int guard;
    model(k, f3, alt, rd, rs1, rs2, imm, e, n, w0, w1);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_kind = 4'(k); bus.in_funct3 = 3'(f3); bus.in_alt = alt;
    bus.in_rd = 5'(rd); bus.in_rs1 = 5'(rs1); bus.in_rs2 = 5'(rs2); bus.in_imm = imm;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    last_err = bus.err;
    if (e) begin
      chk("err_pulse", 32'(bus.err), 32'd1);
      chk("err_no_we", 32'(bus.iw_we), 32'd0);
      chk("err_count", 32'(bus.count), mcount);
      @(negedge clk);
      chk("err_drop", 32'(bus.err), 32'd0);
      chk("err_idle_we", 32'(bus.iw_we), 32'd0);
    end else begin
      chk("we0", 32'(bus.iw_we), 32'd1);
      chk("noerr0", 32'(bus.err), 32'd0);
      chk("addr0", 32'(bus.iw_addr), mcount);
      chk("data0", bus.iw_data, w0);
      last_w0 = bus.iw_data;
      mcount++;
      chk("count0", 32'(bus.count), mcount);
      if (n == 2) begin
        chk("li_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("we1", 32'(bus.iw_we), 32'd1);
        chk("noerr1", 32'(bus.err), 32'd0);
        chk("addr1", 32'(bus.iw_addr), mcount);
        chk("data1", bus.iw_data, w1);
        last_w1 = bus.iw_data;
        mcount++;
        chk("count1", 32'(bus.count), mcount);
      end
      chk("full", 32'(bus.full), (mcount == DEPTH) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mcount = 0;
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("clr_addr", 32'(bus.iw_addr), 32'd0);
    chk("clr_we", 32'(bus.iw_we), 32'd0);
    chk("clr_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_full", 32'(bus.full), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, imm;
    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_funct3 = '0; bus.in_alt = 1'b0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_we", 32'(bus.iw_we), 32'd0);
    chk("rst_addr", 32'(bus.iw_addr), 32'd0);
    chk("rst_data", bus.iw_data, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    do_req(0, 0, 1'b0, 3, 1, 2, 0);
    chk("add_word", last_w0, 32'h002081B3);
    do_req(0, 0, 1'b1, 3, 1, 2, 0);
    chk("sub_word", last_w0, 32'h402081B3);
    do_req(5, 0, 1'b0, 0, 1, 2, -8);
    chk("beq_word", last_w0, 32'hFE208CE3);
    do_req(5, 0, 1'b0, 0, 1, 2, -7);
    chk("beq_odd_err", 32'(last_err), 32'd1);
    do_req(8, 0, 1'b0, 5, 0, 0, 32'h12345FFF);
    chk("li_last_err", 32'(last_err), 32'd1);
    do_req(1, 0, 1'b0, 1, 0, 0, -2048);
    chk("addi_min_word", last_w0, 32'h80000093);
    chk("full_set", 32'(bus.full), 32'd1);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    do_clear();

    do_req(8, 0, 1'b0, 5, 0, 0, 32'h12345FFF);
    chk("li_lui", last_w0, 32'h123462B7);
    chk("li_addi", last_w1, 32'hFFF28293);
    do_req(8, 0, 1'b0, 5, 0, 0, 100);
    chk("li_small", last_w0, 32'h06400293);
    do_req(1, 0, 1'b0, 1, 0, 0, 2048);
    chk("addi_2048_err", 32'(last_err), 32'd1);
    do_clear();

    // Reset arriving while the ADDI half of an LI is pending
    bus.in_kind = 4'd8; bus.in_rd = 5'd5; bus.in_imm = 32'h12345FFF; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rstli_lui_we", 32'(bus.iw_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mcount = 0;
    chk("rstli_we", 32'(bus.iw_we), 32'd0);
    chk("rstli_count", 32'(bus.count), 32'd0);
    chk("rstli_addr", 32'(bus.iw_addr), 32'd0);
    chk("rstli_data", bus.iw_data, 32'd0);
    chk("rstli_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("rstli_no_addi", 32'(bus.iw_we), 32'd0);

    for (int i = 0; i < 400; i++) begin
      if (mcount == DEPTH) begin
        chk("rnd_full", 32'(bus.full), 32'd1);
        chk("rnd_full_ready", 32'(bus.in_ready), 32'd0);
        do_clear();
      end else if ($urandom_range(0, 24) == 0) begin
        do_clear();
      end
      k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      case ($urandom_range(0, 3))
        0: imm = int'($urandom_range(0, 64)) - 32;
        1: imm = bnd[$urandom_range(0, 22)];
        2: imm = int'($urandom);
        default: imm = int'($urandom_range(0, 63));
      endcase
      do_req(k, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
